// File: rtl/bcd_timer_multi.sv
// Parametrised BCD stopwatch/countdown timer with pause, lap capture,
// a wrap-or-saturate overflow policy and a countdown expiry flag.
module bcd_timer_multi #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000,
  parameter bit WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                run,
  input  logic                mode_down,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] lap_val,
  output logic                lap_valid,
  output logic                running,
  output logic                tick,
  output logic                wrapped,
  output logic                expired
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic [W-1:0]    r_count;
  logic [W-1:0]    w_count_nxt;
  logic [W-1:0]    r_lap_val;
  logic            r_lap_valid;
  logic            r_running;
  logic            r_tick;
  logic            r_wrapped;
  logic            r_expired;
  logic            r_mode;
  logic [W-1:0]    w_inc;
  logic [W-1:0]    w_dec;
  logic [W-1:0]    w_load_clamped;
  logic            w_all9;
  logic            w_count_zero;
  logic            w_dec_zero;
  logic            w_load_zero;
  logic            w_tick_nxt;
  logic            w_wrapped_nxt;
  logic            w_expired_nxt;

  // BCD ripple increment/decrement of the current count and digit clamp of load_val
  always_comb begin : ripple_blk
    logic       v_carry;
    logic       v_borrow;
    logic [3:0] v_d;
    logic [3:0] v_l;
    w_inc          = '0;
    w_dec          = '0;
    w_load_clamped = '0;
    v_carry        = 1'b1;
    v_borrow       = 1'b1;
    v_d            = 4'd0;
    v_l            = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      v_d = r_count[4*i +: 4];
      if (v_carry) begin
        if (v_d == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = v_d + 4'd1;
          v_carry         = 1'b0;
        end
      end else begin
        w_inc[4*i +: 4] = v_d;
      end
      if (v_borrow) begin
        if (v_d == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = v_d - 4'd1;
          v_borrow        = 1'b0;
        end
      end else begin
        w_dec[4*i +: 4] = v_d;
      end
      v_l = load_val[4*i +: 4];
      w_load_clamped[4*i +: 4] = (v_l > 4'd9) ? 4'd9 : v_l;
    end
    // A carry surviving every digit means all-9s; a surviving borrow means all-0s.
    w_all9       = v_carry;
    w_count_zero = v_borrow;
  end

  assign w_dec_zero  = (w_dec == '0);
  assign w_load_zero = (w_load_clamped == '0);

  // Next-state, prescaler and count update; counting only while in RUN with run high
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_count_nxt   = r_count;
    w_tick_nxt    = 1'b0;
    w_wrapped_nxt = 1'b0;
    w_expired_nxt = r_expired;
    case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        if (run) w_state_nxt = S_RUN;
        else     w_state_nxt = S_IDLE;
      end
      S_PAUSE: begin
        if (run) w_state_nxt = S_RUN;
        else     w_state_nxt = S_PAUSE;
      end
      S_DONE: begin
        w_presc_nxt = '0;
      end
      S_RUN: begin
        if (!run) begin
          w_state_nxt = S_PAUSE;
        end else if (r_presc == PRESC_LAST) begin
          w_presc_nxt = '0;
          if (r_mode) begin
            if (w_count_zero) begin
              w_expired_nxt = 1'b1;
              w_state_nxt   = S_DONE;
            end else begin
              w_count_nxt = w_dec;
              w_tick_nxt  = 1'b1;
              if (w_dec_zero) begin
                w_expired_nxt = 1'b1;
                w_state_nxt   = S_DONE;
              end else begin
                w_state_nxt = S_RUN;
              end
            end
          end else if (w_all9) begin
            if (WRAP) begin
              w_count_nxt   = '0;
              w_tick_nxt    = 1'b1;
              w_wrapped_nxt = 1'b1;
            end else begin
              w_expired_nxt = 1'b1;
              w_state_nxt   = S_DONE;
            end
          end else begin
            w_count_nxt = w_inc;
            w_tick_nxt  = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
      end
    endcase
  end

  // State and output registers; rst beats restart, restart beats run and lap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_count     <= '0;
      r_lap_val   <= '0;
      r_lap_valid <= 1'b0;
      r_running   <= 1'b0;
      r_tick      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_expired   <= 1'b0;
      r_mode      <= 1'b0;
    end else if (restart) begin
      r_state     <= (mode_down && w_load_zero) ? S_DONE : S_IDLE;
      r_expired   <= mode_down && w_load_zero;
      r_presc     <= '0;
      r_count     <= mode_down ? w_load_clamped : '0;
      r_lap_valid <= 1'b0;
      r_running   <= 1'b0;
      r_tick      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_mode      <= mode_down;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_count   <= w_count_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_tick    <= w_tick_nxt;
      r_wrapped <= w_wrapped_nxt;
      r_expired <= w_expired_nxt;
      if (lap) begin
        r_lap_val   <= r_count;
        r_lap_valid <= 1'b1;
      end else begin
        r_lap_val   <= r_lap_val;
        r_lap_valid <= r_lap_valid;
      end
    end
  end

  assign count     = r_count;
  assign lap_val   = r_lap_val;
  assign lap_valid = r_lap_valid;
  assign running   = r_running;
  assign tick      = r_tick;
  assign wrapped   = r_wrapped;
  assign expired   = r_expired;

endmodule

// File: tb/tb_bcd_timer_multi.sv
// Bench for bcd_timer_multi: three instances (4-digit/div4/wrap, 2-digit/div1
// saturate, 2-digit/div1 wrap) checked every cycle against an integer model.
module tb_bcd_timer_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        run = 1'b0;
  logic        mode_down = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        lap = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] count_a, lap_val_a;
  logic        lap_valid_a, running_a, tick_a, wrapped_a, expired_a;
  logic [7:0]  count_b, lap_val_b;
  logic        lap_valid_b, running_b, tick_b, wrapped_b, expired_b;
  logic [7:0]  count_c, lap_val_c;
  logic        lap_valid_c, running_c, tick_c, wrapped_c, expired_c;

  always #5 clk = ~clk;

  bcd_timer_multi #(.DIGITS(4), .TICK_DIV(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .restart(restart), .run(run), .mode_down(mode_down),
    .load_val(load_val), .lap(lap), .count(count_a), .lap_val(lap_val_a),
    .lap_valid(lap_valid_a), .running(running_a), .tick(tick_a),
    .wrapped(wrapped_a), .expired(expired_a));

  bcd_timer_multi #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .restart(restart), .run(run), .mode_down(mode_down),
    .load_val(load_val[7:0]), .lap(lap), .count(count_b), .lap_val(lap_val_b),
    .lap_valid(lap_valid_b), .running(running_b), .tick(tick_b),
    .wrapped(wrapped_b), .expired(expired_b));

  bcd_timer_multi #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .restart(restart), .run(run), .mode_down(mode_down),
    .load_val(load_val[7:0]), .lap(lap), .count(count_c), .lap_val(lap_val_c),
    .lap_valid(lap_valid_c), .running(running_c), .tick(tick_c),
    .wrapped(wrapped_c), .expired(expired_c));

  // Model state: st 0=idle 1=run 2=pause 3=done; values held as plain integers.
  typedef struct packed {
    int st;
    int val;
    int presc;
    bit mode;
    int lapv;
    bit lapok;
    bit tick;
    bit wrapped;
    bit expired;
  } mdl_t;

  mdl_t m_a = '0;
  mdl_t m_b = '0;
  mdl_t m_c = '0;

  function automatic int bcd_to_int_clamped(logic [31:0] v, int digits);
    int r = 0;
    int w = 1;
    int d;
    for (int i = 0; i < digits; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * w;
      w = w * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] int_to_bcd(int v, int digits);
    logic [31:0] r = 32'h0;
    int x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit f_rst, bit f_restart, bit f_run,
                                 bit f_mode, logic [31:0] f_load, bit f_lap,
                                 int digits, int div, bit wrap);
    mdl_t n = m;
    int maxv = 1;
    repeat (digits) maxv = maxv * 10;
    maxv = maxv - 1;
    n.tick = 1'b0;
    n.wrapped = 1'b0;
    if (f_rst) begin
      n = '0;
    end else if (f_restart) begin
      n.mode = f_mode;
      n.presc = 0;
      n.lapok = 1'b0;
      n.val = f_mode ? bcd_to_int_clamped(f_load, digits) : 0;
      n.expired = f_mode && (n.val == 0);
      n.st = n.expired ? 3 : 0;
    end else begin
      if (f_lap) begin
        n.lapv = m.val;
        n.lapok = 1'b1;
      end
      case (m.st)
        0: begin n.presc = 0; if (f_run) n.st = 1; end
        2: if (f_run) n.st = 1;
        3: n.presc = 0;
        default: begin
          if (!f_run) n.st = 2;
          else if (m.presc == div - 1) begin
            n.presc = 0;
            if (m.mode) begin
              if (m.val > 0) begin
                n.val = m.val - 1;
                n.tick = 1'b1;
              end
              if (n.val == 0) begin n.expired = 1'b1; n.st = 3; end
            end else if (m.val == maxv) begin
              if (wrap) begin n.val = 0; n.tick = 1'b1; n.wrapped = 1'b1; end
              else begin n.expired = 1'b1; n.st = 3; end
            end else begin
              n.val = m.val + 1;
              n.tick = 1'b1;
            end
          end else n.presc = m.presc + 1;
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_a <= mstep(m_a, rst, restart, run, mode_down, {16'h0, load_val}, lap, 4, 4, 1'b1);
    m_b <= mstep(m_b, rst, restart, run, mode_down, {24'h0, load_val[7:0]}, lap, 2, 1, 1'b0);
    m_c <= mstep(m_c, rst, restart, run, mode_down, {24'h0, load_val[7:0]}, lap, 2, 1, 1'b1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      if (errors < 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input int digits,
                          input logic [31:0] cnt, input logic [31:0] lv, input logic lok,
                          input logic rn, input logic tk, input logic wr, input logic ex);
    check({tag, ".count"},     cnt, int_to_bcd(m.val, digits));
    check({tag, ".lap_val"},   lv,  int_to_bcd(m.lapv, digits));
    check({tag, ".lap_valid"}, {31'h0, lok}, {31'h0, m.lapok});
    check({tag, ".running"},   {31'h0, rn},  {31'h0, (m.st == 1)});
    check({tag, ".tick"},      {31'h0, tk},  {31'h0, m.tick});
    check({tag, ".wrapped"},   {31'h0, wr},  {31'h0, m.wrapped});
    check({tag, ".expired"},   {31'h0, ex},  {31'h0, m.expired});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("a", m_a, 4, {16'h0, count_a}, {16'h0, lap_val_a}, lap_valid_a,
               running_a, tick_a, wrapped_a, expired_a);
      cmp_inst("b", m_b, 2, {24'h0, count_b}, {24'h0, lap_val_b}, lap_valid_b,
               running_b, tick_b, wrapped_b, expired_b);
      cmp_inst("c", m_c, 2, {24'h0, count_c}, {24'h0, lap_val_c}, lap_valid_c,
               running_c, tick_c, wrapped_c, expired_c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk_en = 1'b1;
    check("rst_count", {16'h0, count_a}, 32'h0);
    check("rst_running", {31'h0, running_a}, 32'h0);
    check("rst_expired", {31'h0, expired_a}, 32'h0);
    rst = 1'b0;

    // Up count from 0, 40 RUN cycles at divide-by-4
    restart = 1'b1; mode_down = 1'b0;
    cyc(1);
    restart = 1'b0; run = 1'b1;
    cyc(41);
    check("up40_count", {16'h0, count_a}, 32'h0010);
    check("up40_running", {31'h0, running_a}, 32'h1);

    // Pause with prescaler at 2, resume: tick on the second RUN cycle
    cyc(2);
    run = 1'b0;
    cyc(50);
    check("pause_count", {16'h0, count_a}, 32'h0010);
    check("pause_running", {31'h0, running_a}, 32'h0);
    run = 1'b1;
    cyc(2);
    check("resume_no_tick", {31'h0, tick_a}, 32'h0);
    cyc(1);
    check("resume_tick", {31'h0, tick_a}, 32'h1);
    check("resume_count", {16'h0, count_a}, 32'h0011);

    // Down count from 0012 to expiry
    run = 1'b0; restart = 1'b1; mode_down = 1'b1; load_val = 16'h0012;
    cyc(1);
    restart = 1'b0;
    check("down_load", {16'h0, count_a}, 32'h0012);
    run = 1'b1;
    cyc(13);
    check("down_3ticks", {16'h0, count_a}, 32'h0009);
    cyc(36);
    check("down_zero", {16'h0, count_a}, 32'h0000);
    check("down_expired", {31'h0, expired_a}, 32'h1);
    check("down_stopped", {31'h0, running_a}, 32'h0);
    run = 1'b0; restart = 1'b1; load_val = 16'h00A3;
    cyc(1);
    restart = 1'b0;
    check("clamp_load", {16'h0, count_a}, 32'h0093);
    check("clamp_load_b", {24'h0, count_b}, 32'h93);

    // Long up run: 2-digit instances overflow, then lap on the tick to 0138
    restart = 1'b1; mode_down = 1'b0; load_val = 16'h0000;
    cyc(1);
    restart = 1'b0; run = 1'b1;
    cyc(101);
    check("sat_count_b", {24'h0, count_b}, 32'h99);
    check("sat_expired_b", {31'h0, expired_b}, 32'h1);
    check("sat_running_b", {31'h0, running_b}, 32'h0);
    check("wrap_count_c", {24'h0, count_c}, 32'h00);
    check("wrap_pulse_c", {31'h0, wrapped_c}, 32'h1);
    check("wrap_running_c", {31'h0, running_c}, 32'h1);
    cyc(451);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check("lap_val", {16'h0, lap_val_a}, 32'h0137);
    check("lap_valid", {31'h0, lap_valid_a}, 32'h1);
    check("lap_count", {16'h0, count_a}, 32'h0138);
    check("lap_tick", {31'h0, tick_a}, 32'h1);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("rs_lap_valid", {31'h0, lap_valid_a}, 32'h0);
    check("rs_lap_hold", {16'h0, lap_val_a}, 32'h0137);
    check("rs_count", {16'h0, count_a}, 32'h0000);

    // restart beats lap; rst mid-run; down restart with zero load
    restart = 1'b1; lap = 1'b1;
    cyc(1);
    restart = 1'b0; lap = 1'b0;
    check("rs_lap_ignored", {31'h0, lap_valid_a}, 32'h0);
    cyc(10);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; run = 1'b0;
    check("rst2_count", {16'h0, count_a}, 32'h0);
    check("rst2_lap_val", {16'h0, lap_val_a}, 32'h0);
    check("rst2_running", {31'h0, running_a}, 32'h0);
    check("rst2_tick", {31'h0, tick_a}, 32'h0);
    restart = 1'b1; mode_down = 1'b1; load_val = 16'h0000;
    cyc(1);
    restart = 1'b0;
    check("zero_load_expired", {31'h0, expired_a}, 32'h1);
    run = 1'b1;
    cyc(5);
    check("done_running", {31'h0, running_a}, 32'h0);
    check("done_count", {16'h0, count_a}, 32'h0);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
